// File: rtl/axi_xbar.sv
// axi_xbar: 1-to-2 AXI4 crossbar, mtime window to the CLINT, rest to SoC.
// Requests are registered and held stable; one outstanding read and write.
module axi_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_axi_araddr,
  input  logic        in_axi_arvalid,
  input  logic [3:0]  in_axi_arid,
  input  logic [7:0]  in_axi_arlen,
  input  logic [2:0]  in_axi_arsize,
  input  logic [1:0]  in_axi_arburst,
  output logic        in_axi_arready,
  output logic [31:0] in_axi_rdata,
  output logic [1:0]  in_axi_rresp,
  output logic        in_axi_rvalid,
  output logic        in_axi_rlast,
  output logic [3:0]  in_axi_rid,
  input  logic        in_axi_rready,
  input  logic [31:0] in_axi_awaddr,
  input  logic        in_axi_awvalid,
  input  logic [3:0]  in_axi_awid,
  input  logic [7:0]  in_axi_awlen,
  input  logic [2:0]  in_axi_awsize,
  input  logic [1:0]  in_axi_awburst,
  output logic        in_axi_awready,
  input  logic [31:0] in_axi_wdata,
  input  logic [3:0]  in_axi_wstrb,
  input  logic        in_axi_wvalid,
  input  logic        in_axi_wlast,
  output logic        in_axi_wready,
  output logic [1:0]  in_axi_bresp,
  output logic        in_axi_bvalid,
  output logic [3:0]  in_axi_bid,
  input  logic        in_axi_bready,
  output logic [31:0] clint_axi_araddr,
  output logic        clint_axi_arvalid,
  output logic [3:0]  clint_axi_arid,
  output logic [7:0]  clint_axi_arlen,
  output logic [2:0]  clint_axi_arsize,
  output logic [1:0]  clint_axi_arburst,
  input  logic        clint_axi_arready,
  input  logic [31:0] clint_axi_rdata,
  input  logic [1:0]  clint_axi_rresp,
  input  logic        clint_axi_rvalid,
  input  logic        clint_axi_rlast,
  input  logic [3:0]  clint_axi_rid,
  output logic        clint_axi_rready,
  output logic [31:0] clint_axi_awaddr,
  output logic        clint_axi_awvalid,
  output logic [3:0]  clint_axi_awid,
  output logic [7:0]  clint_axi_awlen,
  output logic [2:0]  clint_axi_awsize,
  output logic [1:0]  clint_axi_awburst,
  input  logic        clint_axi_awready,
  output logic [31:0] clint_axi_wdata,
  output logic [3:0]  clint_axi_wstrb,
  output logic        clint_axi_wvalid,
  output logic        clint_axi_wlast,
  input  logic        clint_axi_wready,
  input  logic [1:0]  clint_axi_bresp,
  input  logic        clint_axi_bvalid,
  input  logic [3:0]  clint_axi_bid,
  output logic        clint_axi_bready,
  output logic [31:0] soc_axi_araddr,
  output logic        soc_axi_arvalid,
  output logic [3:0]  soc_axi_arid,
  output logic [7:0]  soc_axi_arlen,
  output logic [2:0]  soc_axi_arsize,
  output logic [1:0]  soc_axi_arburst,
  input  logic        soc_axi_arready,
  input  logic [31:0] soc_axi_rdata,
  input  logic [1:0]  soc_axi_rresp,
  input  logic        soc_axi_rvalid,
  input  logic        soc_axi_rlast,
  input  logic [3:0]  soc_axi_rid,
  output logic        soc_axi_rready,
  output logic [31:0] soc_axi_awaddr,
  output logic        soc_axi_awvalid,
  output logic [3:0]  soc_axi_awid,
  output logic [7:0]  soc_axi_awlen,
  output logic [2:0]  soc_axi_awsize,
  output logic [1:0]  soc_axi_awburst,
  input  logic        soc_axi_awready,
  output logic [31:0] soc_axi_wdata,
  output logic [3:0]  soc_axi_wstrb,
  output logic        soc_axi_wvalid,
  output logic        soc_axi_wlast,
  input  logic        soc_axi_wready,
  input  logic [1:0]  soc_axi_bresp,
  input  logic        soc_axi_bvalid,
  input  logic [3:0]  soc_axi_bid,
  output logic        soc_axi_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_e;

  function automatic logic hit(input logic [31:0] a);
    return (a & CLINT_MASK) == CLINT_BASE;
  endfunction

  r_state_e    r_state_q, r_state_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [3:0]  ar_id_q, ar_id_d;
  logic [7:0]  ar_len_q, ar_len_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [1:0]  ar_burst_q, ar_burst_d;
  logic        rsel_q, rsel_d;

  w_state_e    w_state_q, w_state_d;
  logic        aw_have_q, aw_have_d;
  logic        w_have_q, w_have_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        wsel_q, wsel_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [3:0]  aw_id_q, aw_id_d;
  logic [7:0]  aw_len_q, aw_len_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [1:0]  aw_burst_q, aw_burst_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;

  logic sel_arready, sel_rvalid, sel_rlast;
  logic sel_awready, sel_wready, sel_bvalid;
  logic r_data, w_issue, w_resp;
  logic aw_fire, w_fire;
  logic unused_in;

  assign sel_arready = rsel_q ? clint_axi_arready : soc_axi_arready;
  assign sel_rvalid  = rsel_q ? clint_axi_rvalid  : soc_axi_rvalid;
  assign sel_rlast   = rsel_q ? clint_axi_rlast   : soc_axi_rlast;
  assign sel_awready = wsel_q ? clint_axi_awready : soc_axi_awready;
  assign sel_wready  = wsel_q ? clint_axi_wready  : soc_axi_wready;
  assign sel_bvalid  = wsel_q ? clint_axi_bvalid  : soc_axi_bvalid;

  assign r_data  = r_state_q == R_DATA;
  assign w_issue = w_state_q == W_ISSUE;
  assign w_resp  = w_state_q == W_RESP;

  assign aw_fire = in_axi_awvalid & in_axi_awready;
  assign w_fire  = in_axi_wvalid & in_axi_wready;

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    rsel_d     = rsel_q;
    unique case (r_state_q)
      R_IDLE: if (in_axi_arvalid) begin
        ar_addr_d  = in_axi_araddr;
        ar_id_d    = in_axi_arid;
        ar_len_d   = in_axi_arlen;
        ar_size_d  = in_axi_arsize;
        ar_burst_d = in_axi_arburst;
        rsel_d     = hit(in_axi_araddr);
        r_state_d  = R_ADDR;
      end
      R_ADDR: if (sel_arready) r_state_d = R_DATA;
      R_DATA: if (sel_rvalid && in_axi_rready && sel_rlast)
        r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_have_d  = aw_have_q;
    w_have_d   = w_have_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wsel_d     = wsel_q;
    aw_addr_d  = aw_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_addr_d  = in_axi_awaddr;
          aw_id_d    = in_axi_awid;
          aw_len_d   = in_axi_awlen;
          aw_size_d  = in_axi_awsize;
          aw_burst_d = in_axi_awburst;
          wsel_d     = hit(in_axi_awaddr);
          aw_have_d  = 1'b1;
        end
        if (w_fire) begin
          w_data_d = in_axi_wdata;
          w_strb_d = in_axi_wstrb;
          w_have_d = 1'b1;
        end
        if (aw_have_d && w_have_d) w_state_d = W_ISSUE;
      end
      W_ISSUE: begin
        aw_done_d = aw_done_q | sel_awready;
        w_done_d  = w_done_q | sel_wready;
        if (aw_done_d && w_done_d) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (sel_bvalid && in_axi_bready)
        w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      rsel_q     <= 1'b0;
      w_state_q  <= W_IDLE;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      wsel_q     <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      rsel_q     <= rsel_d;
      w_state_q  <= w_state_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      wsel_q     <= wsel_d;
      aw_addr_q  <= aw_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  assign in_axi_arready = r_state_q == R_IDLE;
  assign in_axi_rvalid  = r_data & sel_rvalid;
  assign in_axi_rdata   = rsel_q ? clint_axi_rdata : soc_axi_rdata;
  assign in_axi_rresp   = rsel_q ? clint_axi_rresp : soc_axi_rresp;
  assign in_axi_rlast   = rsel_q ? clint_axi_rlast : soc_axi_rlast;
  assign in_axi_rid     = ar_id_q;

  assign clint_axi_arvalid = (r_state_q == R_ADDR) & rsel_q;
  assign soc_axi_arvalid   = (r_state_q == R_ADDR) & ~rsel_q;
  assign clint_axi_rready  = r_data & rsel_q & in_axi_rready;
  assign soc_axi_rready    = r_data & ~rsel_q & in_axi_rready;

  // Both slaves see the held request; only valid is steered.
  assign clint_axi_araddr  = ar_addr_q;
  assign clint_axi_arid    = ar_id_q;
  assign clint_axi_arlen   = ar_len_q;
  assign clint_axi_arsize  = ar_size_q;
  assign clint_axi_arburst = ar_burst_q;
  assign soc_axi_araddr    = ar_addr_q;
  assign soc_axi_arid      = ar_id_q;
  assign soc_axi_arlen     = ar_len_q;
  assign soc_axi_arsize    = ar_size_q;
  assign soc_axi_arburst   = ar_burst_q;

  assign in_axi_awready = (w_state_q == W_IDLE) & ~aw_have_q;
  assign in_axi_wready  = (w_state_q == W_IDLE) & ~w_have_q;
  assign in_axi_bvalid  = w_resp & sel_bvalid;
  assign in_axi_bresp   = wsel_q ? clint_axi_bresp : soc_axi_bresp;
  assign in_axi_bid     = aw_id_q;

  assign clint_axi_awvalid = w_issue & wsel_q & ~aw_done_q;
  assign clint_axi_wvalid  = w_issue & wsel_q & ~w_done_q;
  assign soc_axi_awvalid   = w_issue & ~wsel_q & ~aw_done_q;
  assign soc_axi_wvalid    = w_issue & ~wsel_q & ~w_done_q;
  assign clint_axi_bready  = w_resp & wsel_q & in_axi_bready;
  assign soc_axi_bready    = w_resp & ~wsel_q & in_axi_bready;

  assign clint_axi_awaddr  = aw_addr_q;
  assign clint_axi_awid    = aw_id_q;
  assign clint_axi_awlen   = aw_len_q;
  assign clint_axi_awsize  = aw_size_q;
  assign clint_axi_awburst = aw_burst_q;
  assign clint_axi_wdata   = w_data_q;
  assign clint_axi_wstrb   = w_strb_q;
  assign clint_axi_wlast   = 1'b1;
  assign soc_axi_awaddr    = aw_addr_q;
  assign soc_axi_awid      = aw_id_q;
  assign soc_axi_awlen     = aw_len_q;
  assign soc_axi_awsize    = aw_size_q;
  assign soc_axi_awburst   = aw_burst_q;
  assign soc_axi_wdata     = w_data_q;
  assign soc_axi_wstrb     = w_strb_q;
  assign soc_axi_wlast     = 1'b1;

  // Slave ids are replaced by the latched ids; writes are single-beat.
  assign unused_in = ^{in_axi_wlast, clint_axi_rid, soc_axi_rid,
                       clint_axi_bid, soc_axi_bid};

endmodule

// File: tb/tb_axi_xbar.sv
// tb_axi_xbar: directed stimulus with two slave models and a response
// scoreboard popped by an independent monitor.
module tb_axi_xbar;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] in_araddr, in_rdata, in_awaddr, in_wdata;
  logic [3:0]  in_arid, in_rid, in_awid, in_wstrb, in_bid;
  logic [7:0]  in_arlen, in_awlen;
  logic [2:0]  in_arsize, in_awsize;
  logic [1:0]  in_arburst, in_rresp, in_awburst, in_bresp;
  logic in_arvalid, in_arready, in_rvalid, in_rlast, in_rready;
  logic in_awvalid, in_awready, in_wvalid, in_wlast, in_wready;
  logic in_bvalid, in_bready;

  // index 0 = SoC, 1 = CLINT
  logic [31:0] m_araddr [2];
  logic        m_arvalid [2];
  logic [3:0]  m_arid [2];
  logic [7:0]  m_arlen [2];
  logic [2:0]  m_arsize [2];
  logic [1:0]  m_arburst [2];
  logic        m_rready [2];
  logic [31:0] m_awaddr [2];
  logic        m_awvalid [2];
  logic [3:0]  m_awid [2];
  logic [7:0]  m_awlen [2];
  logic [2:0]  m_awsize [2];
  logic [1:0]  m_awburst [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic        m_wvalid [2];
  logic        m_wlast [2];
  logic        m_bready [2];

  logic        s_arready [2];
  logic [31:0] s_rdata [2];
  logic [1:0]  s_rresp [2];
  logic        s_rvalid [2];
  logic        s_rlast [2];
  logic [3:0]  s_rid [2];
  logic        s_awready [2];
  logic        s_wready [2];
  logic [1:0]  s_bresp [2];
  logic        s_bvalid [2];
  logic [3:0]  s_bid [2];

  axi_xbar dut (
    .clk(clk), .rst(rst),
    .in_axi_araddr(in_araddr), .in_axi_arvalid(in_arvalid),
    .in_axi_arid(in_arid), .in_axi_arlen(in_arlen),
    .in_axi_arsize(in_arsize), .in_axi_arburst(in_arburst),
    .in_axi_arready(in_arready), .in_axi_rdata(in_rdata),
    .in_axi_rresp(in_rresp), .in_axi_rvalid(in_rvalid),
    .in_axi_rlast(in_rlast), .in_axi_rid(in_rid),
    .in_axi_rready(in_rready),
    .in_axi_awaddr(in_awaddr), .in_axi_awvalid(in_awvalid),
    .in_axi_awid(in_awid), .in_axi_awlen(in_awlen),
    .in_axi_awsize(in_awsize), .in_axi_awburst(in_awburst),
    .in_axi_awready(in_awready), .in_axi_wdata(in_wdata),
    .in_axi_wstrb(in_wstrb), .in_axi_wvalid(in_wvalid),
    .in_axi_wlast(in_wlast), .in_axi_wready(in_wready),
    .in_axi_bresp(in_bresp), .in_axi_bvalid(in_bvalid),
    .in_axi_bid(in_bid), .in_axi_bready(in_bready),
    .clint_axi_araddr(m_araddr[1]), .clint_axi_arvalid(m_arvalid[1]),
    .clint_axi_arid(m_arid[1]), .clint_axi_arlen(m_arlen[1]),
    .clint_axi_arsize(m_arsize[1]), .clint_axi_arburst(m_arburst[1]),
    .clint_axi_arready(s_arready[1]), .clint_axi_rdata(s_rdata[1]),
    .clint_axi_rresp(s_rresp[1]), .clint_axi_rvalid(s_rvalid[1]),
    .clint_axi_rlast(s_rlast[1]), .clint_axi_rid(s_rid[1]),
    .clint_axi_rready(m_rready[1]),
    .clint_axi_awaddr(m_awaddr[1]), .clint_axi_awvalid(m_awvalid[1]),
    .clint_axi_awid(m_awid[1]), .clint_axi_awlen(m_awlen[1]),
    .clint_axi_awsize(m_awsize[1]), .clint_axi_awburst(m_awburst[1]),
    .clint_axi_awready(s_awready[1]), .clint_axi_wdata(m_wdata[1]),
    .clint_axi_wstrb(m_wstrb[1]), .clint_axi_wvalid(m_wvalid[1]),
    .clint_axi_wlast(m_wlast[1]), .clint_axi_wready(s_wready[1]),
    .clint_axi_bresp(s_bresp[1]), .clint_axi_bvalid(s_bvalid[1]),
    .clint_axi_bid(s_bid[1]), .clint_axi_bready(m_bready[1]),
    .soc_axi_araddr(m_araddr[0]), .soc_axi_arvalid(m_arvalid[0]),
    .soc_axi_arid(m_arid[0]), .soc_axi_arlen(m_arlen[0]),
    .soc_axi_arsize(m_arsize[0]), .soc_axi_arburst(m_arburst[0]),
    .soc_axi_arready(s_arready[0]), .soc_axi_rdata(s_rdata[0]),
    .soc_axi_rresp(s_rresp[0]), .soc_axi_rvalid(s_rvalid[0]),
    .soc_axi_rlast(s_rlast[0]), .soc_axi_rid(s_rid[0]),
    .soc_axi_rready(m_rready[0]),
    .soc_axi_awaddr(m_awaddr[0]), .soc_axi_awvalid(m_awvalid[0]),
    .soc_axi_awid(m_awid[0]), .soc_axi_awlen(m_awlen[0]),
    .soc_axi_awsize(m_awsize[0]), .soc_axi_awburst(m_awburst[0]),
    .soc_axi_awready(s_awready[0]), .soc_axi_wdata(m_wdata[0]),
    .soc_axi_wstrb(m_wstrb[0]), .soc_axi_wvalid(m_wvalid[0]),
    .soc_axi_wlast(m_wlast[0]), .soc_axi_wready(s_wready[0]),
    .soc_axi_bresp(s_bresp[0]), .soc_axi_bvalid(s_bvalid[0]),
    .soc_axi_bid(s_bid[0]), .soc_axi_bready(m_bready[0])
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;
  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];
  int n_chk = 0;
  int n_pass = 0;

  // slave model configuration and observations
  int          cfg_ar_dly [2], cfg_aw_dly [2], cfg_w_dly [2];
  logic [31:0] cfg_rbase [2];
  logic [1:0]  cfg_rresp [2], cfg_bresp [2];
  int rd_busy [2], rd_beat [2], rd_len [2], ar_seen [2];
  int aw_got [2], w_got [2], wr_resp [2], aw_seen [2], w_seen [2];
  int ar_cnt [2], aw_cnt [2], w_cnt [2], b_cnt [2];
  int arv_cyc [2], awv_cyc [2], wv_cyc [2], both_seen [2];
  int stab_err [2];
  logic [31:0] ar_rec_addr [2], aw_rec_addr [2], w_rec_data [2];
  logic [3:0]  ar_rec_id [2];
  logic        w_rec_last [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Slave models: sample at negedge, drive just after posedge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      cfg_ar_dly[k] = 0; cfg_aw_dly[k] = 0; cfg_w_dly[k] = 0;
      cfg_rbase[k] = '0; cfg_rresp[k] = '0; cfg_bresp[k] = '0;
      rd_busy[k] = 0; rd_beat[k] = 0; rd_len[k] = 0; ar_seen[k] = 0;
      aw_got[k] = 0; w_got[k] = 0; wr_resp[k] = 0;
      aw_seen[k] = 0; w_seen[k] = 0;
      ar_cnt[k] = 0; aw_cnt[k] = 0; w_cnt[k] = 0; b_cnt[k] = 0;
      arv_cyc[k] = 0; awv_cyc[k] = 0; wv_cyc[k] = 0;
      both_seen[k] = 0; stab_err[k] = 0;
      ar_rec_addr[k] = '0; aw_rec_addr[k] = '0; w_rec_data[k] = '0;
      ar_rec_id[k] = '0; w_rec_last[k] = 1'b0;
      s_arready[k] = 0; s_rdata[k] = '0; s_rresp[k] = '0;
      s_rvalid[k] = 0; s_rlast[k] = 0; s_rid[k] = 4'hF;
      s_awready[k] = 0; s_wready[k] = 0; s_bresp[k] = '0;
      s_bvalid[k] = 0; s_bid[k] = 4'hE;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          rd_busy[k] = 0; ar_seen[k] = 0; aw_got[k] = 0; w_got[k] = 0;
          wr_resp[k] = 0; aw_seen[k] = 0; w_seen[k] = 0;
        end else begin
          if (m_arvalid[k]) arv_cyc[k]++;
          if (rd_busy[k] == 0) begin
            if (m_arvalid[k] && s_arready[k]) begin
              rd_busy[k] = 1; rd_beat[k] = 0; rd_len[k] = int'(m_arlen[k]);
              ar_rec_addr[k] = m_araddr[k]; ar_rec_id[k] = m_arid[k];
              ar_cnt[k]++; ar_seen[k] = 0;
            end else if (m_arvalid[k]) ar_seen[k]++;
          end else begin
            if (m_araddr[k] !== ar_rec_addr[k]) stab_err[k]++;
            if (s_rvalid[k] && m_rready[k]) begin
              if (rd_beat[k] == rd_len[k]) rd_busy[k] = 0;
              else rd_beat[k]++;
            end
          end
          if (m_awvalid[k]) awv_cyc[k]++;
          if (m_wvalid[k]) wv_cyc[k]++;
          if (m_awvalid[k] && m_wvalid[k]) both_seen[k]++;
          if (wr_resp[k] == 0) begin
            if (m_awvalid[k] && s_awready[k]) begin
              aw_got[k] = 1; aw_cnt[k]++; aw_rec_addr[k] = m_awaddr[k];
            end else if (m_awvalid[k]) aw_seen[k]++;
            if (m_wvalid[k] && s_wready[k]) begin
              w_got[k] = 1; w_cnt[k]++; w_rec_data[k] = m_wdata[k];
              w_rec_last[k] = m_wlast[k];
            end else if (m_wvalid[k]) w_seen[k]++;
            if (aw_got[k] != 0 && w_got[k] != 0) wr_resp[k] = 1;
          end else if (s_bvalid[k] && m_bready[k]) begin
            wr_resp[k] = 0; aw_got[k] = 0; w_got[k] = 0;
            aw_seen[k] = 0; w_seen[k] = 0; b_cnt[k]++;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        s_arready[k] = (rd_busy[k] == 0) && (ar_seen[k] >= cfg_ar_dly[k]);
        s_rvalid[k]  = rd_busy[k] != 0;
        s_rdata[k]   = cfg_rbase[k] + 32'(rd_beat[k]);
        s_rlast[k]   = rd_beat[k] == rd_len[k];
        s_rresp[k]   = cfg_rresp[k];
        s_awready[k] = (wr_resp[k] == 0) && (aw_got[k] == 0) &&
                       (aw_seen[k] >= cfg_aw_dly[k]);
        s_wready[k]  = (wr_resp[k] == 0) && (w_got[k] == 0) &&
                       (w_seen[k] >= cfg_w_dly[k]);
        s_bvalid[k]  = wr_resp[k] != 0;
        s_bresp[k]   = cfg_bresp[k];
      end
    end
  end

  // Monitor: pops the scoreboard on every master-side handshake.
  initial begin
    r_exp_t re;
    b_exp_t be;
    forever begin
      @(negedge clk);
      if (!rst && in_rvalid && in_rready) begin
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL r_unexpected: got beat %0h expected none",
                   in_rdata);
        end else begin
          re = rq.pop_front();
          chk("rdata", in_rdata, re.data);
          chk("rresp", 32'(in_rresp), 32'(re.resp));
          chk("rlast", 32'(in_rlast), 32'(re.last));
          chk("rid", 32'(in_rid), 32'(re.id));
        end
      end
      if (!rst && in_bvalid && in_bready) begin
        if (bq.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected: got resp %0h expected none",
                   in_bresp);
        end else begin
          be = bq.pop_front();
          chk("bresp", 32'(in_bresp), 32'(be.resp));
          chk("bid", 32'(in_bid), 32'(be.id));
        end
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len);
    int n;
    bit hs;
    @(posedge clk);
    #1;
    in_araddr = a; in_arid = id; in_arlen = len;
    in_arsize = 3'd2; in_arburst = 2'b01; in_arvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = in_arready;
      n++;
    end
    n_chk++;
    if (hs) n_pass++;
    else $display("FAIL ar_handshake: got timeout expected accept");
    @(posedge clk);
    #1 in_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [31:0] base,
                         input logic [1:0] resp);
    for (int b = 0; b <= int'(len); b++)
      rq.push_back('{base + 32'(b), resp, b == int'(len), id});
    do_ar(a, id, len);
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] id);
    int n;
    bit hs;
    @(posedge clk);
    #1;
    in_awaddr = a; in_awid = id; in_awlen = 8'd0;
    in_awsize = 3'd2; in_awburst = 2'b01; in_awvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = in_awready;
      n++;
    end
    n_chk++;
    if (hs) n_pass++;
    else $display("FAIL aw_handshake: got timeout expected accept");
    @(posedge clk);
    #1 in_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int n;
    bit hs;
    @(posedge clk);
    #1;
    in_wdata = d; in_wstrb = 4'hF; in_wlast = 1'b1; in_wvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = in_wready;
      n++;
    end
    n_chk++;
    if (hs) n_pass++;
    else $display("FAIL w_handshake: got timeout expected accept");
    @(posedge clk);
    #1 in_wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
                          input logic [31:0] d, input logic [1:0] resp,
                          input int w_lead);
    bq.push_back('{resp, id});
    fork
      send_w(d);
      begin
        repeat (w_lead) @(posedge clk);
        send_aw(a, id);
      end
    join
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(rq.size() + bq.size()), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic logic [9:0] slave_ctl();
    return {m_arvalid[0], m_arvalid[1], m_awvalid[0], m_awvalid[1],
            m_wvalid[0], m_wvalid[1], m_rready[0], m_rready[1],
            m_bready[0], m_bready[1]};
  endfunction

  initial begin
    int a0, a1, c0, c1, s1, bs1, b0, b1, wv0, awv0;
    int bad, n;
    bit seen;
    rst = 1'b1;
    in_araddr = '0; in_arid = '0; in_arlen = '0; in_arsize = '0;
    in_arburst = '0; in_arvalid = 1'b0; in_rready = 1'b1;
    in_awaddr = '0; in_awid = '0; in_awlen = '0; in_awsize = '0;
    in_awburst = '0; in_awvalid = 1'b0;
    in_wdata = '0; in_wstrb = '0; in_wlast = 1'b0; in_wvalid = 1'b0;
    in_bready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arready", 32'(in_arready), 1);
    chk("rst_awready", 32'(in_awready), 1);
    chk("rst_wready", 32'(in_wready), 1);
    chk("rst_rvalid", 32'(in_rvalid), 0);
    chk("rst_bvalid", 32'(in_bvalid), 0);
    chk("rst_slave_ctl", 32'(slave_ctl()), 0);

    // CLINT single read; slave rid is wrong on purpose
    settle();
    cfg_rbase[1] = 32'h1234; cfg_rresp[1] = 2'b00;
    a0 = arv_cyc[0]; s1 = stab_err[1];
    do_read(32'h0200_0000, 4'd5, 8'd0, 32'h1234, 2'b00);
    @(negedge clk);
    chk("clint_arvalid_t1", 32'(m_arvalid[1]), 1);
    drain();
    chk("clint_araddr", ar_rec_addr[1], 32'h0200_0000);
    chk("clint_arid", 32'(ar_rec_id[1]), 5);
    chk("clint_araddr_stable", 32'(stab_err[1] - s1), 0);
    chk("soc_arvalid_never", 32'(arv_cyc[0] - a0), 0);

    // SoC 4-beat burst
    cfg_rbase[0] = 32'h5000; cfg_rresp[0] = 2'b00;
    c0 = ar_cnt[0];
    do_read(32'h8000_0000, 4'd2, 8'd3, 32'h5000, 2'b00);
    bad = 0; seen = 0; n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (in_arready) bad++;
      if (in_rvalid && in_rready && in_rlast) seen = 1;
      n++;
    end
    chk("arready_low_in_burst", 32'(bad), 0);
    chk("burst_rlast_seen", 32'(seen), 1);
    @(negedge clk);
    chk("arready_after_rlast", 32'(in_arready), 1);
    drain();
    chk("soc_one_ar", 32'(ar_cnt[0] - c0), 1);

    // CLINT write, W two cycles ahead of AW, SLVERR forwarded
    cfg_bresp[1] = 2'b10;
    bs1 = both_seen[1]; b1 = b_cnt[1];
    do_write(32'h0200_0004, 4'd7, 32'hDEAD_BEEF, 2'b10, 2);
    drain();
    chk("clint_aw_w_together", 32'(both_seen[1] - bs1), 1);
    chk("clint_awaddr", aw_rec_addr[1], 32'h0200_0004);
    chk("clint_wdata", w_rec_data[1], 32'hDEAD_BEEF);
    chk("clint_wlast", 32'(w_rec_last[1]), 1);
    chk("clint_one_b", 32'(b_cnt[1] - b1), 1);

    // concurrent CLINT read and SoC write
    cfg_rbase[1] = 32'hAAAA_0000; cfg_bresp[0] = 2'b00;
    c0 = ar_cnt[0]; c1 = ar_cnt[1]; a0 = aw_cnt[0]; a1 = aw_cnt[1];
    fork
      do_read(32'h0200_0008, 4'd3, 8'd0, 32'hAAAA_0000, 2'b00);
      do_write(32'h8000_0010, 4'd9, 32'h0000_0055, 2'b00, 0);
    join
    drain();
    chk("conc_clint_ar", 32'(ar_cnt[1] - c1), 1);
    chk("conc_soc_ar", 32'(ar_cnt[0] - c0), 0);
    chk("conc_soc_aw", 32'(aw_cnt[0] - a0), 1);
    chk("conc_clint_aw", 32'(aw_cnt[1] - a1), 0);
    chk("conc_soc_wdata", w_rec_data[0], 32'h0000_0055);

    // SoC holds awready off for 3 cycles
    cfg_aw_dly[0] = 3;
    wv0 = wv_cyc[0]; awv0 = awv_cyc[0]; b0 = b_cnt[0];
    do_write(32'h9000_0000, 4'd4, 32'h0BAD_F00D, 2'b00, 0);
    drain();
    cfg_aw_dly[0] = 0;
    chk("soc_wvalid_cycles", 32'(wv_cyc[0] - wv0), 1);
    chk("soc_awvalid_cycles", 32'(awv_cyc[0] - awv0), 4);
    chk("soc_one_b", 32'(b_cnt[0] - b0), 1);

    // decode boundaries; CLINT error resp passes through
    cfg_rbase[1] = 32'h11; cfg_rresp[1] = 2'b01; cfg_rbase[0] = 32'h22;
    c0 = ar_cnt[0]; c1 = ar_cnt[1];
    do_read(32'h0200_FFFF, 4'd1, 8'd0, 32'h11, 2'b01);
    do_read(32'h0201_0000, 4'd2, 8'd0, 32'h22, 2'b00);
    do_read(32'h01FF_FFFC, 4'd3, 8'd0, 32'h22, 2'b00);
    drain();
    chk("edge_clint_ar", 32'(ar_cnt[1] - c1), 1);
    chk("edge_soc_ar", 32'(ar_cnt[0] - c0), 2);

    // reset while in R_DATA
    cfg_rresp[1] = 2'b00;
    in_rready = 1'b0;
    do_ar(32'h0200_0020, 4'd6, 8'd0);
    seen = 0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = in_rvalid;
      n++;
    end
    chk("rdata_phase_reached", 32'(seen), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_arready", 32'(in_arready), 1);
    chk("mid_rst_rvalid", 32'(in_rvalid), 0);
    chk("mid_rst_slave_ctl", 32'(slave_ctl()), 0);
    in_rready = 1'b1;
    cfg_rbase[0] = 32'h77;
    do_read(32'h8000_0040, 4'd8, 8'd0, 32'h77, 2'b00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
